compare_sweeper: RTL
====================

COMPARE_SWEEPER -- requirements
Module: compare_sweeper

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4, clock cycles each operand pair is held (legal 2..255).
REQ-002 SHALL have parameter EXPECT_GT, default 6, expected count of pairs with a>b for the 2-bit sweep.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  level-sampled request to begin a sweep.
REQ-006 SHALL have port a_out  output  2  operand a driven to the downstream 2-bit greater-than comparator.
REQ-007 SHALL have port b_out  output  2  operand b driven to the same comparator.
REQ-008 SHALL have port g_in  input  1  comparator result (1 = a>b), combinational from a_out/b_out.
REQ-009 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a sweep completes.
REQ-011 SHALL have port gt_count  output  5  number of pairs for which g_in was sampled high (0..16).

Function
REQ-012 SHALL implement FSM states IDLE, SWEEP, DONE; reset state IDLE.
REQ-013 SHALL, in IDLE with start=1, go to SWEEP next edge, clear idx (4-bit), tick counter and gt_count.
REQ-014 SHALL drive a_out=idx[1:0], b_out=idx[3:2] (a[0] toggles fastest, b[1] slowest).
REQ-015 SHALL hold each idx for exactly TICK_DIV cycles; sample g_in on the last cycle of the hold only.
REQ-016 SHALL increment gt_count by 1 on each sample where g_in=1; saturation is unnecessary (max 16 fits).
REQ-017 SHALL increment idx after each sample; after sampling idx=15 go to DONE, no wrap to 0 in SWEEP.
REQ-018 SHALL assert busy exactly in SWEEP; sweep length = 16*TICK_DIV cycles.
REQ-019 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-020 SHALL ignore start while in SWEEP or DONE; start held high in IDLE re-triggers a new sweep.
REQ-021 SHALL hold gt_count stable in IDLE and DONE until the next sweep starts.
REQ-022 SHALL drive a_out=b_out=0 in IDLE and DONE.

Reset
REQ-023 SHALL, on rst_n low at any time including mid-sweep, immediately force IDLE, idx=0, tick=0, a_out=0, b_out=0, busy=0, done=0, gt_count=0 (and pass=0 when present).
REQ-024 SHALL leave IDLE only on a rising clk edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with SWEEP_SELF_CHECK_EN defined, add output pass (1 bit), set in DONE to (gt_count==EXPECT_GT) and held until next start/reset.
REQ-026 SHALL, without SWEEP_SELF_CHECK_EN, have no pass port and no compare logic.

Structure
REQ-027 SHALL place FSM state enum, operand width (2) and pair count (16) in shared package compare_sweeper_pkg.
REQ-028 SHALL implement hold timing in one sub-module tick_gen (counter 0..TICK_DIV-1, outputs last-cycle strobe, synchronous clear).

Verification
REQ-029 SHALL check: ideal comparator (g=a>b), TICK_DIV=4, start pulse -> busy 64 cycles, done pulse, gt_count=6.
REQ-030 SHALL check: g_in tied 0 -> gt_count=0; g_in tied 1 -> gt_count=16.
REQ-031 SHALL check: operand sequence a_out/b_out steps (0,0),(1,0),(2,0),(3,0),(0,1)...(3,3), each held 4 cycles.
REQ-032 SHALL check: start pulsed at cycle 20 of a sweep -> ignored, done still at cycle 64, single sweep.
REQ-033 SHALL check: rst_n low at cycle 30 -> all outputs 0 same cycle; new start -> clean full sweep, gt_count=6.
REQ-034 SHALL check: SWEEP_SELF_CHECK_EN defined -> pass=1 with ideal comparator, pass=0 with g_in tied 1.

Source files
------------

// File: rtl/compare_sweeper_pkg.sv
// Shared types and sizes for the 2-bit comparator sweeper.
package compare_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } sweep_state_t;

  localparam int OPW    = 2;
  localparam int NPAIRS = 16;
  localparam int IDXW   = 2 * OPW;
  localparam int CNTW   = 5;

  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NPAIRS - 1);

endpackage

// File: rtl/compare_sweeper_tick_gen.sv
// Hold-time divider: counts 0..TICK_DIV-1 while enabled and strobes on the last count.
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last
);

  localparam logic [7:0] LAST_CNT = 8'(TICK_DIV - 1);

  logic [7:0] r_cnt;
  logic       w_at_last;

  assign w_at_last = (r_cnt == LAST_CNT);
  assign o_last    = i_en && w_at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_last ? 8'd0 : r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/compare_sweeper.sv
// Sweeps all 16 operand pairs through an external 2-bit a>b comparator and counts hits.
// Optional `pass` output when SWEEP_SELF_CHECK_EN is defined.
module compare_sweeper
  import compare_sweeper_pkg::*;
#(
  parameter int TICK_DIV  = 4,
  parameter int EXPECT_GT = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [OPW-1:0]  a_out,
  output logic [OPW-1:0]  b_out,
  input  logic            g_in,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] gt_count
`ifdef SWEEP_SELF_CHECK_EN
  ,
  output logic            pass
`endif
);

  sweep_state_t    r_state;
  sweep_state_t    w_state_next;
  logic [IDXW-1:0] r_idx;
  logic [CNTW-1:0] r_gt_count;
  logic [CNTW-1:0] w_gt_next;
  logic            w_tick_last;
  logic            w_in_sweep;
  logic            w_launch;
  logic            w_final_sample;

  assign w_in_sweep     = (r_state == ST_SWEEP);
  assign w_launch       = (r_state == ST_IDLE) && start;
  assign w_final_sample = w_in_sweep && w_tick_last && (r_idx == IDX_LAST);
  assign w_gt_next      = r_gt_count + {{(CNTW-1){1'b0}}, g_in};

  // Counter is held at zero outside SWEEP so every sweep starts on a fresh hold.
  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (!w_in_sweep),
    .i_en   (w_in_sweep),
    .o_last (w_tick_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_SWEEP;
      ST_SWEEP: if (w_final_sample) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_gt_count <= '0;
    end else if (w_launch) begin
      r_idx      <= '0;
      r_gt_count <= '0;
    end else if (w_in_sweep && w_tick_last) begin
      r_gt_count <= w_gt_next;
      if (r_idx != IDX_LAST) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

`ifdef SWEEP_SELF_CHECK_EN
  logic r_pass;

  // Evaluated with the final sample folded in so the verdict is visible during DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass <= 1'b0;
    end else if (w_launch) begin
      r_pass <= 1'b0;
    end else if (w_final_sample) begin
      r_pass <= (w_gt_next == CNTW'(EXPECT_GT));
    end
  end

  assign pass = r_pass;
`endif

  assign a_out    = w_in_sweep ? r_idx[OPW-1:0]      : '0;
  assign b_out    = w_in_sweep ? r_idx[IDXW-1:OPW]   : '0;
  assign busy     = w_in_sweep;
  assign done     = (r_state == ST_DONE);
  assign gt_count = r_gt_count;

endmodule
